instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Writer side of the instruction memory: it fills the 256-word instruction store that the fetch stage reads by PC.
- Accepts a burst of 32-bit instruction words over a valid/ready stream, e.g. from a host or UART bridge.
- Writes each accepted word to consecutive memory addresses through a single registered write port.
- Holds the CPU in halt while loading, then reports completion, a 32-bit additive checksum and an error status.

Parameters:
DATA_W, 32, instruction word width
ADDR_W, 8, instruction memory address width
DEPTH, 256, instruction memory depth in words (must equal 2**ADDR_W)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
start  input  1  load command, sampled only in IDLE
base_addr  input  ADDR_W  first memory address to write
word_count  input  ADDR_W+1  number of words to load, 1..DEPTH
abort  input  1  cancels a load in progress
in_valid  input  1  stream word valid
in_data  input  DATA_W  stream instruction word
in_ready  output  1  loader accepts a word this cycle
mem_we  output  1  instruction memory write enable
mem_addr  output  ADDR_W  write address
mem_wdata  output  DATA_W  write data
cpu_halt  output  1  processor must not fetch/advance
busy  output  1  load in progress
done  output  1  one-cycle pulse on successful completion
error  output  1  sticky error flag, cleared by the next accepted start
checksum  output  DATA_W  sum mod 2^32 of the words loaded so far

Behaviour:
- Reset (reset=0, async): state=IDLE. in_ready, mem_we, cpu_halt, busy, done and error = 0. mem_addr, mem_wdata and checksum = 0. Internal address and remaining counters = 0.
- States: IDLE, LOAD, DONE.
- IDLE, start=1 with word_count==0 or base_addr+word_count>DEPTH (computed ADDR_W+1 bits wide):
  - error<=1; stay IDLE; nothing is written.
- IDLE, start=1 with a legal command:
  - latch base_addr and word_count; checksum<=0; error<=0; go to LOAD.
- LOAD:
  - in_ready = (state==LOAD), combinational from state; busy=1; cpu_halt=1.
  - A handshake occurs when in_valid & in_ready.
  - On a handshake: next cycle mem_we=1, mem_addr=current address, mem_wdata=in_data. This is a fixed 1-cycle write latency.
  - Also on a handshake: checksum<=checksum+in_data (wraps mod 2^32); address+1; remaining-1.
  - Without a handshake, mem_we=0 the next cycle. Gaps in in_valid are allowed with no limit.
  - The handshake that accepts the last word transitions to DONE.
- DONE, exactly one cycle:
  - mem_we=1 for the last word; done=1; busy=1; cpu_halt=1; in_ready=0.
  - Next state IDLE, where cpu_halt=0, busy=0 and done=0.
- abort=1 in LOAD:
  - takes priority over a same-cycle handshake; that word is not written and not summed.
  - go to IDLE; error<=1. Words already written stay in memory. No done pulse.
- start in LOAD or DONE is ignored. abort in IDLE or DONE is ignored.
- Address never wraps, because the range check guarantees it. A load with base_addr+word_count==DEPTH ends on address DEPTH-1.
- word_count==DEPTH with base 0 is legal and fills the full memory.
- reset asserted mid-load: all outputs return to reset values immediately, including mem_we=0. A partial image remains in memory.
- checksum holds its value in IDLE until the next legal start.

Decomposition:
- Shared package:
  - state enum (IDLE/LOAD/DONE);
  - DATA_W, ADDR_W and DEPTH constants, shared with fetch and the instruction memory.
- One natural sub-module: instr_mem_loader_wrport.
  - Registered write-port stage: mem_we/mem_addr/mem_wdata pipeline register plus checksum accumulator.
  - Keeps the FSM separate from the datapath.

Test Plan:
- Reset then idle -> all outputs 0; in_ready=0; mem_we never asserts.
- start, base=0x10, count=3; stream 0x11111111, 0x22222222, 0x33333333 back-to-back -> writes at 0x10/0x11/0x12, each 1 cycle after its handshake. done pulses once in the cycle of the third write. checksum=0x66666666. cpu_halt high from the cycle after start through DONE.
- Same load with in_valid gaps of 2 cycles -> identical writes and checksum. in_ready stays 1 in LOAD. No mem_we during the gaps.
- start, base=0xFE, count=3 -> error=1, no writes, stays IDLE. start, base=0x00, count=0 -> error=1. start, base=0xFF, count=1 -> single write at 0xFF, done pulse.
- start, count=4; after 2 words, abort=1 with in_valid=1 -> exactly 2 writes, error=1, no done pulse, IDLE next cycle. A following legal start clears error.
- Drop reset to 0 during LOAD after 1 word -> mem_we, busy and cpu_halt fall immediately. After release, in_ready=0 until a new start.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and FSM state type for the instruction-memory loader.
// Widths here are also used by fetch and the instruction memory itself.
package instr_mem_loader_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Stream input and instruction-memory write port of the loader.
// The master side feeds words and observes writes; the slave side is the loader.
interface instr_mem_loader_if #(
   parameter int DATA_W = instr_mem_loader_pkg::DATA_W,
   parameter int ADDR_W = instr_mem_loader_pkg::ADDR_W
);

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/instr_mem_loader_wrport.sv
// Registered write-port stage: every accepted word appears on the memory port
// exactly one cycle later, and the running checksum advances on the same edge.
module instr_mem_loader_wrport #(
   parameter int DATA_W = instr_mem_loader_pkg::DATA_W,
   parameter int ADDR_W = instr_mem_loader_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              sum_clr,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] checksum
);

   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] checksum_q,  checksum_d;

   always_comb begin
      mem_we_d    = wr_en;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      checksum_d  = checksum_q;
      if (wr_en) begin
         mem_addr_d  = wr_addr;
         mem_wdata_d = wr_data;
         checksum_d  = checksum_q + wr_data;
      end
      // Clear only comes from IDLE, so it never collides with a write.
      if (sum_clr) begin
         checksum_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         checksum_q  <= '0;
      end else begin
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         checksum_q  <= checksum_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign checksum  = checksum_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a burst of instruction words into consecutive addresses of the
// instruction store while holding the CPU in halt; reports done/error/checksum.
module instr_mem_loader #(
   parameter int DATA_W = instr_mem_loader_pkg::DATA_W,
   parameter int ADDR_W = instr_mem_loader_pkg::ADDR_W,
   parameter int DEPTH  = instr_mem_loader_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   input  logic              abort,
   instr_mem_loader_if.slave bus,
   output logic              cpu_halt,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [DATA_W-1:0] checksum
);

   import instr_mem_loader_pkg::*;

   localparam logic [ADDR_W+1:0] DEPTH_X = (ADDR_W+2)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

   state_e            state_q,     state_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic              error_q,     error_d;

   logic [ADDR_W+1:0] end_addr;
   logic              cmd_ok;
   logic              hs;
   logic              last_word;
   logic              sum_clr;

   // One spare bit so an out-of-range word_count cannot wrap past the check.
   assign end_addr  = {2'b00, base_addr} + {1'b0, word_count};
   assign cmd_ok    = (word_count != '0) && (end_addr <= DEPTH_X);

   assign bus.in_ready = (state_q == LOAD);
   assign hs           = bus.in_valid & bus.in_ready & ~abort;
   assign last_word    = (remaining_q == CNT_ONE);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      error_d     = error_q;
      sum_clr     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (cmd_ok) begin
                  state_d     = LOAD;
                  addr_d      = base_addr;
                  remaining_d = word_count;
                  error_d     = 1'b0;
                  sum_clr     = 1'b1;
               end else begin
                  error_d     = 1'b1;
               end
            end
         end
         LOAD: begin
            if (abort) begin
               state_d = IDLE;
               error_d = 1'b1;
            end else if (hs) begin
               remaining_d = remaining_q - CNT_ONE;
               // Holding the address on the last word keeps a top-of-memory load from wrapping.
               if (last_word) begin
                  state_d = DONE;
               end else begin
                  addr_d  = addr_q + ADR_ONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         error_q     <= error_d;
      end
   end

   instr_mem_loader_wrport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_wrport (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (hs),
      .wr_addr   (addr_q),
      .wr_data   (bus.in_data),
      .sum_clr   (sum_clr),
      .mem_we    (bus.mem_we),
      .mem_addr  (bus.mem_addr),
      .mem_wdata (bus.mem_wdata),
      .checksum  (checksum)
   );

   assign busy     = (state_q != IDLE);
   assign cpu_halt = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign error    = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a per-cycle behavioural model plus
// literal expectations on the written image, checksum and pulse counts.
module tb_instr_mem_loader;

   import instr_mem_loader_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   word_count = '0;
   logic              cpu_halt, busy, done, error;
   logic [DATA_W-1:0] checksum;

   instr_mem_loader_if bus ();

   always #5 clk = ~clk;

   instr_mem_loader dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .abort      (abort),
      .bus        (bus),
      .cpu_halt   (cpu_halt),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .checksum   (checksum)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: loading flag, done cycle, next address, words left, sum.
   bit          m_load, m_done, m_err, m_we;
   int          m_addr, m_left;
   logic [31:0] m_sum, m_waddr, m_wdata;

   always @(posedge clk or negedge reset) begin : model
      bit          nload, ndone, nerr, take;
      int          naddr, nleft;
      logic [31:0] nsum;
      if (!reset) begin
         m_load <= 0; m_done <= 0; m_err <= 0; m_we <= 0;
         m_addr <= 0; m_left <= 0; m_sum <= 0; m_waddr <= 0; m_wdata <= 0;
      end else begin
         nload = m_load; nerr = m_err; naddr = m_addr; nleft = m_left; nsum = m_sum;
         ndone = 0;
         take  = m_load && bus.in_valid && !abort;
         if (!m_load && !m_done && start) begin
            if (word_count == 0 || int'(base_addr) + int'(word_count) > DEPTH) nerr = 1;
            else begin
               nload = 1; naddr = base_addr; nleft = word_count; nsum = 0; nerr = 0;
            end
         end else if (m_load && abort) begin
            nload = 0; nerr = 1;
         end else if (take) begin
            nsum  = m_sum + bus.in_data;
            naddr = m_addr + 1;
            nleft = m_left - 1;
            if (nleft == 0) begin nload = 0; ndone = 1; end
         end
         m_load <= nload; m_done <= ndone; m_err <= nerr;
         m_addr <= naddr; m_left <= nleft; m_sum <= nsum;
         m_we   <= take;
         if (take) begin
            m_waddr <= m_addr;
            m_wdata <= bus.in_data;
         end
      end
   end

   // Observed memory image and event counts, for the literal checks.
   logic [31:0] img [DEPTH];
   int n_writes, n_done, n_done_we;

   always @(negedge clk) begin
      if (!reset) begin
         chk("rst in_ready", bus.in_ready, 0);
         chk("rst mem_we", bus.mem_we, 0);
         chk("rst busy", busy, 0);
         chk("rst cpu_halt", cpu_halt, 0);
         chk("rst done", done, 0);
         chk("rst error", error, 0);
         chk("rst checksum", checksum, 0);
         chk("rst mem_addr", bus.mem_addr, 0);
         chk("rst mem_wdata", bus.mem_wdata, 0);
      end else begin
         chk("in_ready", bus.in_ready, m_load);
         chk("busy", busy, m_load | m_done);
         chk("cpu_halt", cpu_halt, m_load | m_done);
         chk("done", done, m_done);
         chk("error", error, m_err);
         chk("checksum", checksum, m_sum);
         chk("mem_we", bus.mem_we, m_we);
         if (m_we) begin
            chk("mem_addr", bus.mem_addr, m_waddr);
            chk("mem_wdata", bus.mem_wdata, m_wdata);
         end
         if (bus.mem_we) begin
            img[bus.mem_addr] = bus.mem_wdata;
            n_writes++;
         end
         if (done) n_done++;
         if (done && bus.mem_we) n_done_we++;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      for (int i = 0; i < DEPTH; i++) img[i] = '0;
      n_writes = 0; n_done = 0; n_done_we = 0;
   endtask

   task automatic load_cmd(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
      start = 1'b1; base_addr = b; word_count = c;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input int gap);
      bus.in_valid = 1'b1; bus.in_data = d;
      tick();
      bus.in_valid = 1'b0;
      if (gap > 0) tick(gap);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      clear_log();
      tick(3);
      reset = 1'b1;
      tick(4);
      chk("idle mem_addr", bus.mem_addr, 32'h0);
      chk("idle mem_wdata", bus.mem_wdata, 32'h0);
      chk("idle no writes", n_writes, 0);

      // Back-to-back and gapped bursts of the same image.
      for (int g = 0; g <= 2; g += 2) begin
         clear_log();
         load_cmd(8'h10, 9'd3);
         send(32'h11111111, g);
         send(32'h22222222, g);
         send(32'h33333333, g);
         tick(3);
         chk("burst writes", n_writes, 3);
         chk("burst img10", img[8'h10], 32'h11111111);
         chk("burst img11", img[8'h11], 32'h22222222);
         chk("burst img12", img[8'h12], 32'h33333333);
         chk("burst checksum", checksum, 32'h66666666);
         chk("burst done pulses", n_done, 1);
         chk("burst done with last write", n_done_we, 1);
      end

      // Range check and the top-of-memory single word.
      clear_log();
      load_cmd(8'hFE, 9'd3);
      tick();
      chk("range err", error, 1);
      chk("range idle", busy, 0);
      chk("range checksum held", checksum, 32'h66666666);
      load_cmd(8'hFF, 9'd1);
      chk("legal start clears err", error, 0);
      send(32'hDEADBEEF, 0);
      tick(2);
      chk("top img ff", img[8'hFF], 32'hDEADBEEF);
      chk("top done", n_done, 1);
      load_cmd(8'h00, 9'd0);
      tick();
      chk("zero count err", error, 1);
      chk("range section writes", n_writes, 1);
      chk("zero count checksum held", checksum, 32'hDEADBEEF);

      // Full-memory load, word i = i.
      clear_log();
      load_cmd(8'h00, 9'd256);
      for (int i = 0; i < DEPTH; i++) send(32'(i), 0);
      tick(3);
      chk("full writes", n_writes, 256);
      chk("full img0", img[0], 32'h0);
      chk("full img80", img[8'h80], 32'h80);
      chk("full imgff", img[8'hFF], 32'hFF);
      chk("full checksum", checksum, 32'h00007F80);
      chk("full done", n_done, 1);

      // Abort wins over a same-cycle handshake.
      clear_log();
      load_cmd(8'h20, 9'd4);
      send(32'h0000000A, 0);
      send(32'h0000000B, 0);
      bus.in_valid = 1'b1; bus.in_data = 32'h0000000C; abort = 1'b1;
      tick();
      abort = 1'b0; bus.in_valid = 1'b0;
      chk("abort idle", busy, 0);
      chk("abort err", error, 1);
      tick(2);
      chk("abort writes", n_writes, 2);
      chk("abort img22", img[8'h22], 32'h0);
      chk("abort no done", n_done, 0);
      chk("abort checksum", checksum, 32'h00000015);
      load_cmd(8'h30, 9'd1);
      chk("restart clears err", error, 0);
      send(32'h00000077, 0);
      tick(2);

      // Reset mid-load.
      clear_log();
      load_cmd(8'h40, 9'd4);
      send(32'h00000055, 0);
      @(negedge clk);
      #1;
      chk("pre-reset mem_we", bus.mem_we, 1);
      reset = 1'b0;
      #1;
      chk("reset mem_we", bus.mem_we, 0);
      chk("reset busy", busy, 0);
      chk("reset cpu_halt", cpu_halt, 0);
      chk("reset in_ready", bus.in_ready, 0);
      tick(2);
      reset = 1'b1;
      bus.in_valid = 1'b1; bus.in_data = 32'h00000099;
      tick(3);
      chk("post-reset in_ready", bus.in_ready, 0);
      bus.in_valid = 1'b0;
      tick(2);
      chk("reset partial writes", n_writes, 1);
      chk("reset partial img40", img[8'h40], 32'h00000055);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
